// File: rtl/bp_cfg_loader_pkg.sv
// Shared types for the configuration loader: FSM state encoding and a
// width-parameterised table entry struct generated by a macro so that each
// user can stamp it out with its own address/data widths.
`ifndef BP_CFG_LOADER_PKG_SV
`define BP_CFG_LOADER_PKG_SV

`define BP_CFG_ENTRY_S(addr_w, data_w) \
  typedef struct packed { \
    logic [addr_w-1:0] addr; \
    logic [data_w-1:0] data; \
  } bp_cfg_entry_s

package bp_cfg_loader_pkg;

  typedef enum logic [2:0] {
    e_idle    = 3'd0,
    e_send    = 3'd1,
    e_rd_req  = 3'd2,
    e_rd_wait = 3'd3,
    e_done    = 3'd4
  } bp_cfg_loader_state_e;

endpackage

`endif

// File: rtl/bp_cfg_loader_table.sv
// Configuration table: tbl_els_p entries of {addr, data}, one write port and
// one asynchronous read port. Contents are intentionally not reset so a
// programmed table survives a loader reset.
module bp_cfg_loader_table
  import bp_cfg_loader_pkg::*;
#(
  parameter int cfg_addr_width_p = 16,
  parameter int cfg_data_width_p = 64,
  parameter int tbl_els_p        = 8,
  localparam int lg_tbl_els_lp   = $clog2(tbl_els_p)
) (
  input  logic                        clk_i,
  input  logic                        w_v_i,
  input  logic [lg_tbl_els_lp-1:0]    w_idx_i,
  input  logic [cfg_addr_width_p-1:0] w_addr_i,
  input  logic [cfg_data_width_p-1:0] w_data_i,
  input  logic [lg_tbl_els_lp-1:0]    r_idx_i,
  output logic [cfg_addr_width_p-1:0] r_addr_o,
  output logic [cfg_data_width_p-1:0] r_data_o
);

  `BP_CFG_ENTRY_S(cfg_addr_width_p, cfg_data_width_p);

  bp_cfg_entry_s mem_q [tbl_els_p];

  // Table write port; no reset on storage.
  always_ff @(posedge clk_i) begin
    if (w_v_i) begin
      mem_q[w_idx_i] <= '{addr: w_addr_i, data: w_data_i};
    end
  end

  assign r_addr_o = mem_q[r_idx_i].addr;
  assign r_data_o = mem_q[r_idx_i].data;

endmodule

// File: rtl/bp_cfg_loader_multi.sv
// Sequential configuration loader. Broadcasts the first `count` table entries
// to every core enabled in a mask over a valid/ready config link, core by core.
// Optional feature macro: BP_CFG_LOADER_READBACK_EN -- each write is followed
// by a read of the same register, and a data mismatch sets a sticky error_o.
module bp_cfg_loader_multi
  import bp_cfg_loader_pkg::*;
#(
  parameter int num_core_p       = 16,
  parameter int cfg_core_width_p = 8,
  parameter int cfg_addr_width_p = 16,
  parameter int cfg_data_width_p = 64,
  parameter int tbl_els_p        = 8,
  localparam int lg_tbl_els_lp   = $clog2(tbl_els_p)
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        tbl_w_v_i,
  input  logic [lg_tbl_els_lp-1:0]    tbl_w_idx_i,
  input  logic [cfg_addr_width_p-1:0] tbl_w_addr_i,
  input  logic [cfg_data_width_p-1:0] tbl_w_data_i,
  input  logic                        start_i,
  input  logic [lg_tbl_els_lp:0]      count_i,
  input  logic [num_core_p-1:0]       core_mask_i,
  output logic                        busy_o,
  output logic                        done_o,
  output logic                        cfg_v_o,
  output logic                        cfg_w_o,
  output logic [cfg_core_width_p-1:0] cfg_core_o,
  output logic [cfg_addr_width_p-1:0] cfg_addr_o,
  output logic [cfg_data_width_p-1:0] cfg_data_o,
  input  logic                        cfg_ready_i,
  input  logic                        cfg_rdata_v_i,
  input  logic [cfg_data_width_p-1:0] cfg_rdata_i,
  output logic                        error_o
);

  // Core index is one bit wider than needed so it can represent num_core_p;
  // the mask is zero-padded to the full index range so any index is legal.
  localparam int core_w_lp     = $clog2(num_core_p + 1);
  localparam int mask_ext_w_lp = 1 << core_w_lp;
  localparam logic [core_w_lp-1:0]     core_one_lp  = 1;
  localparam logic [core_w_lp-1:0]     core_last_lp = core_w_lp'(num_core_p - 1);
  localparam logic [lg_tbl_els_lp-1:0] entry_one_lp = 1;
  localparam logic [lg_tbl_els_lp:0]   cnt_one_lp   = 1;

  bp_cfg_loader_state_e state_q, state_d;
  logic [lg_tbl_els_lp:0]      count_q, count_d;
  logic [num_core_p-1:0]       mask_q, mask_d;
  logic [lg_tbl_els_lp-1:0]    entry_q, entry_d;
  logic [core_w_lp-1:0]        core_q, core_d;
  logic                        busy_q, busy_d;
  logic                        done_q, done_d;
  logic                        error_q, error_d;
  logic                        cfg_v_q, cfg_v_d;
  logic                        cfg_w_q, cfg_w_d;
  logic [cfg_core_width_p-1:0] cfg_core_q, cfg_core_d;
  logic [cfg_addr_width_p-1:0] cfg_addr_q, cfg_addr_d;
  logic [cfg_data_width_p-1:0] cfg_data_q, cfg_data_d;

  logic [mask_ext_w_lp-1:0]    mask_ext_q, mask_ext_d;
  logic                        higher_en;
  logic                        last_entry;
  logic                        advance;
  logic [cfg_addr_width_p-1:0] tbl_r_addr;
  logic [cfg_data_width_p-1:0] tbl_r_data;

  assign mask_ext_q = {{(mask_ext_w_lp - num_core_p){1'b0}}, mask_q};
  assign mask_ext_d = {{(mask_ext_w_lp - num_core_p){1'b0}}, mask_d};
  assign last_entry = ({1'b0, entry_q} == (count_q - cnt_one_lp));

  // Table reads the entry the next cycle will present, so the read happens
  // before any same-edge write lands (read-before-write on start).
  bp_cfg_loader_table #(
    .cfg_addr_width_p(cfg_addr_width_p),
    .cfg_data_width_p(cfg_data_width_p),
    .tbl_els_p       (tbl_els_p)
  ) u_table (
    .clk_i   (clk_i),
    .w_v_i   (tbl_w_v_i && (state_q == e_idle)),
    .w_idx_i (tbl_w_idx_i),
    .w_addr_i(tbl_w_addr_i),
    .w_data_i(tbl_w_data_i),
    .r_idx_i (entry_d),
    .r_addr_o(tbl_r_addr),
    .r_data_o(tbl_r_data)
  );

  // Is any core above the current one still enabled?
  always_comb begin
    higher_en = 1'b0;
    for (int i = 0; i < mask_ext_w_lp; i++) begin
      if (mask_ext_q[i] && (core_w_lp'(i) > core_q)) higher_en = 1'b1;
    end
  end

  // Sequencer next-state: walk entries within a core, then move to the next core.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    mask_d  = mask_q;
    entry_d = entry_q;
    core_d  = core_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    error_d = error_q;
    advance = 1'b0;
    case (state_q)
      e_idle: begin
        if (start_i) begin
          count_d = count_i;
          mask_d  = core_mask_i;
          entry_d = '0;
          core_d  = '0;
          error_d = 1'b0;
          busy_d  = 1'b1;
          state_d = ((count_i == '0) || (core_mask_i == '0)) ? e_done : e_send;
        end
      end
      e_send: begin
        if (!cfg_v_q) begin
          // Masked-off core: one skip cycle, then the next core.
          if ((core_q == core_last_lp) || !higher_en) state_d = e_done;
          else core_d = core_q + core_one_lp;
        end else if (cfg_ready_i) begin
`ifdef BP_CFG_LOADER_READBACK_EN
          state_d = e_rd_req;
`else
          advance = 1'b1;
`endif
        end
      end
`ifdef BP_CFG_LOADER_READBACK_EN
      e_rd_req: begin
        if (cfg_ready_i) state_d = e_rd_wait;
      end
      e_rd_wait: begin
        if (cfg_rdata_v_i) begin
          if (cfg_rdata_i != cfg_data_q) error_d = 1'b1;
          advance = 1'b1;
        end
      end
`endif
      e_done: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = e_idle;
      end
      default: state_d = e_idle;
    endcase

    if (advance) begin
      state_d = e_send;
      if (last_entry) begin
        entry_d = '0;
        if (!higher_en || (core_q == core_last_lp)) state_d = e_done;
        else core_d = core_q + core_one_lp;
      end else begin
        entry_d = entry_q + entry_one_lp;
      end
    end
  end

  // Link outputs for the next cycle, derived from the next state and indices.
  always_comb begin
    cfg_v_d    = 1'b0;
    cfg_w_d    = 1'b0;
    cfg_core_d = cfg_core_q;
    cfg_addr_d = cfg_addr_q;
    cfg_data_d = cfg_data_q;
    if (state_d == e_send) begin
      cfg_v_d    = mask_ext_d[core_d];
      cfg_w_d    = mask_ext_d[core_d];
      cfg_core_d = cfg_core_width_p'(core_d);
      cfg_addr_d = tbl_r_addr;
      cfg_data_d = tbl_r_data;
    end
`ifdef BP_CFG_LOADER_READBACK_EN
    else if (state_d == e_rd_req) begin
      cfg_v_d = 1'b1;
      cfg_w_d = 1'b0;
    end
`endif
  end

  // Single FSM/output register bank; everything visible on the link is registered.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= e_idle;
      count_q    <= '0;
      mask_q     <= '0;
      entry_q    <= '0;
      core_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      cfg_v_q    <= 1'b0;
      cfg_w_q    <= 1'b0;
      cfg_core_q <= '0;
      cfg_addr_q <= '0;
      cfg_data_q <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      mask_q     <= mask_d;
      entry_q    <= entry_d;
      core_q     <= core_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
      cfg_v_q    <= cfg_v_d;
      cfg_w_q    <= cfg_w_d;
      cfg_core_q <= cfg_core_d;
      cfg_addr_q <= cfg_addr_d;
      cfg_data_q <= cfg_data_d;
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign cfg_v_o    = cfg_v_q;
  assign cfg_w_o    = cfg_w_q;
  assign cfg_core_o = cfg_core_q;
  assign cfg_addr_o = cfg_addr_q;
  assign cfg_data_o = cfg_data_q;

`ifdef BP_CFG_LOADER_READBACK_EN
  assign error_o = error_q;
`else
  logic unused_rdata;
  assign unused_rdata = ^{cfg_rdata_v_i, cfg_rdata_i, error_q};
  assign error_o      = 1'b0;
`endif

endmodule

// File: tb/tb_bp_cfg_loader_multi.sv
// Self-checking bench for bp_cfg_loader_multi. A reference model expands the
// table and mask into the expected ordered list of write transactions and the
// expected completion cycle; scenarios drive random backpressure and compare.
module tb_bp_cfg_loader_multi;

  localparam int NC = 16;
  localparam int CW = 8;
  localparam int AW = 16;
  localparam int DW = 64;
  localparam int TE = 8;
  localparam int LG = 3;

  logic          clk = 1'b0;
  logic          reset_i;
  logic          tbl_w_v_i;
  logic [LG-1:0] tbl_w_idx_i;
  logic [AW-1:0] tbl_w_addr_i;
  logic [DW-1:0] tbl_w_data_i;
  logic          start_i;
  logic [LG:0]   count_i;
  logic [NC-1:0] core_mask_i;
  logic          busy_o, done_o, cfg_v_o, cfg_w_o, error_o;
  logic [CW-1:0] cfg_core_o;
  logic [AW-1:0] cfg_addr_o;
  logic [DW-1:0] cfg_data_o;
  logic          cfg_ready_i;
  logic          cfg_rdata_v_i;
  logic [DW-1:0] cfg_rdata_i;

  always #5 clk = ~clk;

  bp_cfg_loader_multi #(
    .num_core_p(NC), .cfg_core_width_p(CW), .cfg_addr_width_p(AW),
    .cfg_data_width_p(DW), .tbl_els_p(TE)
  ) dut (
    .clk_i(clk), .reset_i(reset_i),
    .tbl_w_v_i(tbl_w_v_i), .tbl_w_idx_i(tbl_w_idx_i),
    .tbl_w_addr_i(tbl_w_addr_i), .tbl_w_data_i(tbl_w_data_i),
    .start_i(start_i), .count_i(count_i), .core_mask_i(core_mask_i),
    .busy_o(busy_o), .done_o(done_o),
    .cfg_v_o(cfg_v_o), .cfg_w_o(cfg_w_o), .cfg_core_o(cfg_core_o),
    .cfg_addr_o(cfg_addr_o), .cfg_data_o(cfg_data_o),
    .cfg_ready_i(cfg_ready_i), .cfg_rdata_v_i(cfg_rdata_v_i),
    .cfg_rdata_i(cfg_rdata_i), .error_o(error_o)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [AW-1:0] m_addr [TE];
  logic [DW-1:0] m_data [TE];
  logic [AW-1:0] bad_addr = '0;
  bit            bad_en   = 1'b0;

  typedef struct {
    int            core;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } xact_t;

  task automatic tbl_write(input int idx, input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    tbl_w_v_i    = 1'b1;
    tbl_w_idx_i  = LG'(idx);
    tbl_w_addr_i = a;
    tbl_w_data_i = d;
    @(negedge clk);
    tbl_w_v_i = 1'b0;
    m_addr[idx] = a;
    m_data[idx] = d;
  endtask

  // One load sequence checked against the model.
  // stall_pct: random ready-low percentage; hold_hs: write handshake index that
  // gets ready held low for 5 cycles (-1 none); poke_k: cycle at which start and
  // a table write are pulsed while busy (0 none).
  task automatic run_load(input int cnt, input logic [NC-1:0] mask, input int stall_pct,
                          input int hold_hs, input int poke_k, input string tag);
    xact_t         exp_q[$];
    xact_t         x;
    int            k, hs, hi, skips, n_exp, done_k, stall_left;
    bit            exp_err, rd_pend;
    logic          pv, pr;
    logic [CW-1:0] pc;
    logic [AW-1:0] pa, last_wa;
    logic [DW-1:0] pd, last_wd;

    hi = -1;
    for (int c = 0; c < NC; c++) if (mask[c]) hi = c;
    exp_err = 1'b0;
    if (cnt > 0) begin
      for (int c = 0; c < NC; c++) begin
        if (mask[c]) begin
          for (int e = 0; e < cnt; e++) begin
            x.core = c; x.addr = m_addr[e]; x.data = m_data[e];
            exp_q.push_back(x);
            if (bad_en && (m_addr[e] == bad_addr)) exp_err = 1'b1;
          end
        end
      end
    end
    skips = 0;
    if (cnt > 0) for (int c = 0; c < hi; c++) if (!mask[c]) skips++;
    n_exp = exp_q.size();

    @(negedge clk);
    start_i = 1'b1; count_i = 4'(cnt); core_mask_i = mask;
    @(negedge clk);
    start_i = 1'b0;

    k = 1; hs = 0; done_k = 0; pv = 1'b0; pr = 1'b0; stall_left = 5; rd_pend = 1'b0;
    pc = '0; pa = '0; pd = '0; last_wa = '0; last_wd = '0;
    while (k < 3000) begin
      if (k == 1) begin
        n_cmp++;
        if ({busy_o, error_o} !== 2'b10) begin
          n_bad++;
          $display("FAIL %s busy/error after start: got %b required 10", tag, {busy_o, error_o});
        end
      end
      cfg_rdata_v_i = rd_pend;
      if (rd_pend) cfg_rdata_i = last_wd ^ ((bad_en && last_wa == bad_addr) ? 64'd1 : 64'd0);
      rd_pend = 1'b0;
      if (done_o) begin
        done_k = k;
        break;
      end
      if (pv && !pr) begin
        n_cmp++;
        if ({cfg_v_o, cfg_core_o, cfg_addr_o, cfg_data_o} !== {pv, pc, pa, pd}) begin
          n_bad++;
          $display("FAIL %s stall hold k=%0d: got core %h addr %h data %h required core %h addr %h data %h",
                   tag, k, cfg_core_o, cfg_addr_o, cfg_data_o, pc, pa, pd);
        end
      end
      if (hold_hs >= 0 && hs == hold_hs && cfg_v_o && cfg_w_o && stall_left > 0) begin
        cfg_ready_i = 1'b0;
        stall_left--;
      end else begin
        cfg_ready_i = ($urandom_range(99) >= stall_pct);
      end
      if (k == poke_k) begin
        start_i = 1'b1; tbl_w_v_i = 1'b1; tbl_w_idx_i = 3'd1;
        tbl_w_addr_i = 16'hDEAD; tbl_w_data_i = '1;
      end else begin
        start_i = 1'b0; tbl_w_v_i = 1'b0;
      end
`ifndef BP_CFG_LOADER_READBACK_EN
      if (cfg_v_o) begin
        n_cmp++;
        if (cfg_w_o !== 1'b1) begin
          n_bad++;
          $display("FAIL %s cfg_w while valid: got %b required 1", tag, cfg_w_o);
        end
      end
`endif
      if (cfg_v_o && cfg_ready_i && cfg_w_o) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL %s extra write: got core %h addr %h required none", tag, cfg_core_o, cfg_addr_o);
        end else begin
          x = exp_q.pop_front();
          if (cfg_core_o !== CW'(x.core) || cfg_addr_o !== x.addr || cfg_data_o !== x.data) begin
            n_bad++;
            $display("FAIL %s write %0d: got core %h addr %h data %h required core %h addr %h data %h",
                     tag, hs, cfg_core_o, cfg_addr_o, cfg_data_o, CW'(x.core), x.addr, x.data);
          end
        end
        hs++;
        last_wa = cfg_addr_o;
        last_wd = cfg_data_o;
      end
`ifdef BP_CFG_LOADER_READBACK_EN
      if (cfg_v_o && cfg_ready_i && !cfg_w_o) begin
        n_cmp++;
        if (cfg_addr_o !== last_wa) begin
          n_bad++;
          $display("FAIL %s readback addr: got %h required %h", tag, cfg_addr_o, last_wa);
        end
        rd_pend = 1'b1;
      end
`endif
      pv = cfg_v_o; pr = cfg_ready_i; pc = cfg_core_o; pa = cfg_addr_o; pd = cfg_data_o;
      @(negedge clk);
      k++;
    end
    start_i = 1'b0; tbl_w_v_i = 1'b0; cfg_ready_i = 1'b1; cfg_rdata_v_i = 1'b0;

    n_cmp++;
    if (done_k == 0) begin
      n_bad++;
      $display("FAIL %s done timeout: got no done_o required pulse", tag);
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL %s missing writes: got %0d left required 0", tag, exp_q.size());
    end
    n_cmp++;
    if ({busy_o, cfg_v_o, error_o} !== {2'b00, exp_err}) begin
      n_bad++;
      $display("FAIL %s at done busy/v/err: got %b required %b", tag, {busy_o, cfg_v_o, error_o}, {2'b00, exp_err});
    end
`ifndef BP_CFG_LOADER_READBACK_EN
    if (stall_pct == 0 && hold_hs < 0) begin
      n_cmp++;
      if (done_k != n_exp + skips + 2) begin
        n_bad++;
        $display("FAIL %s done cycle: got %0d required %0d", tag, done_k, n_exp + skips + 2);
      end
    end
`endif
    @(negedge clk);
    n_cmp++;
    if ({done_o, busy_o, error_o} !== {2'b00, exp_err}) begin
      n_bad++;
      $display("FAIL %s after done: got done/busy/err %b required %b", tag, {done_o, busy_o, error_o}, {2'b00, exp_err});
    end
  endtask

  task automatic test_reset();
    reset_i = 1'b1; tbl_w_v_i = 1'b0; tbl_w_idx_i = '0; tbl_w_addr_i = '0; tbl_w_data_i = '0;
    start_i = 1'b0; count_i = '0; core_mask_i = '0; cfg_ready_i = 1'b1;
    cfg_rdata_v_i = 1'b0; cfg_rdata_i = '0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({busy_o, done_o, cfg_v_o, cfg_w_o, error_o} !== 5'b0) begin
      n_bad++;
      $display("FAIL reset ctl: got %b required 00000", {busy_o, done_o, cfg_v_o, cfg_w_o, error_o});
    end
    n_cmp++;
    if ({cfg_core_o, cfg_addr_o, cfg_data_o} !== '0) begin
      n_bad++;
      $display("FAIL reset fields: got core %h addr %h data %h required 0", cfg_core_o, cfg_addr_o, cfg_data_o);
    end
    reset_i = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({busy_o, done_o, cfg_v_o} !== 3'b0) begin
      n_bad++;
      $display("FAIL idle after reset: got %b required 000", {busy_o, done_o, cfg_v_o});
    end
  endtask

  task automatic load_basic_table();
    tbl_write(0, 16'h0010, 64'hAAAA);
    tbl_write(1, 16'h0020, 64'h5555);
    tbl_write(2, 16'h0030, 64'h0001);
  endtask

  task automatic test_basic();
    load_basic_table();
    run_load(3, 16'h0005, 0, -1, 0, "basic");
  endtask

  task automatic test_empty();
    run_load(0, 16'h000F, 0, -1, 0, "empty_cnt");
    run_load(2, 16'h0000, 0, -1, 0, "empty_mask");
  endtask

  task automatic test_backpressure();
    run_load(3, 16'h0005, 0, 1, 0, "backpressure");
  endtask

  task automatic test_busy_guard();
    run_load(3, 16'h0005, 0, -1, 3, "busy_poke");
    run_load(3, 16'h0005, 0, -1, 0, "busy_rerun");
  endtask

  task automatic test_reset_mid();
    int seen;
    bit hit;
    seen = 0; hit = 1'b0;
    cfg_ready_i = 1'b1;
    @(negedge clk);
    start_i = 1'b1; count_i = 4'd3; core_mask_i = 16'h0005;
    @(negedge clk);
    start_i = 1'b0;
    cfg_rdata_v_i = 1'b1; cfg_rdata_i = '0;
    for (int i = 0; i < 50; i++) begin
      if (cfg_v_o && cfg_w_o) seen++;
      if (seen == 2) begin
        reset_i = 1'b1;
        #1;
        hit = 1'b1;
        n_cmp++;
        if ({cfg_v_o, busy_o, done_o} !== 3'b000) begin
          n_bad++;
          $display("FAIL reset_mid async drop: got v/busy/done %b required 000", {cfg_v_o, busy_o, done_o});
        end
        break;
      end
      @(negedge clk);
    end
    n_cmp++;
    if (!hit) begin
      n_bad++;
      $display("FAIL reset_mid second write: got %0d writes required 2", seen);
    end
    cfg_rdata_v_i = 1'b0;
    @(negedge clk);
    reset_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({done_o, busy_o, cfg_v_o} !== 3'b000) begin
        n_bad++;
        $display("FAIL reset_mid idle: got done/busy/v %b required 000", {done_o, busy_o, cfg_v_o});
      end
    end
    run_load(3, 16'h0005, 0, -1, 0, "reset_replay");
  endtask

  task automatic test_random();
    int            cnt, pct;
    logic [NC-1:0] mask;
    for (int it = 0; it < 8; it++) begin
      for (int e = 0; e < TE; e++)
        tbl_write(e, AW'($urandom), {32'($urandom), 32'($urandom)});
      cnt  = $urandom_range(TE, 0);
      mask = NC'($urandom & $urandom);
      if (it == 3) mask = '0;
      if (it == 5) mask = 16'h8000;
      pct  = (it < 2) ? 0 : $urandom_range(40, 0);
      run_load(cnt, mask, pct, -1, 0, "random");
    end
  endtask

`ifdef BP_CFG_LOADER_READBACK_EN
  task automatic test_readback();
    load_basic_table();
    bad_en = 1'b1; bad_addr = 16'h0010;
    run_load(3, 16'h0005, 20, -1, 0, "readback_bad");
    bad_en = 1'b0;
    run_load(3, 16'h0005, 0, -1, 0, "readback_clean");
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_empty();
    test_backpressure();
    test_busy_guard();
    test_reset_mid();
    test_random();
`ifdef BP_CFG_LOADER_READBACK_EN
    test_readback();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
